// File: rtl/exponent_arbiter.sv
// Round-robin arbiter and sequencer sharing one exponent unit (p = x^a) among
// NUM_REQ requesters, with a WAIT-state timeout that returns an error result.
module exponent_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [32*NUM_REQ-1:0]        x_in,
  input  logic [32*NUM_REQ-1:0]        a_in,
  output logic [NUM_REQ-1:0]           done,
  output logic                         error,
  output logic [31:0]                  p_out,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         exp_enable,
  output logic [31:0]                  exp_x,
  output logic [31:0]                  exp_a,
  input  logic                         exp_ready,
  input  logic [31:0]                  exp_p
);

  localparam int DATA_W = 32;
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int CW     = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, SKIP, WAIT, DONE} state_t;

  state_t              state, state_nx;
  logic [IDW-1:0]      ptr;
  logic [CW-1:0]       cnt;
  logic                found;
  logic [IDW-1:0]      sel;
  logic                wait_to;

  // Search upward from ptr with wrap-around for the first pending request.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign wait_to = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   state_nx = SKIP;
      SKIP:    state_nx = WAIT;
      WAIT:    if (exp_ready || wait_to) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Every output is a register; busy/enable are precomputed from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= '0;
      error      <= 1'b0;
      p_out      <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      exp_enable <= 1'b0;
      exp_x      <= '0;
      exp_a      <= '0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      busy       <= (state_nx != IDLE);
      exp_enable <= (state_nx == ISSUE);
      done       <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= sel;
            exp_x    <= x_in[DATA_W*sel +: DATA_W];
            exp_a    <= a_in[DATA_W*sel +: DATA_W];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (exp_ready) begin
            p_out          <= exp_p;
            error          <= 1'b0;
            done[grant_id] <= 1'b1;
          end else if (wait_to) begin
            p_out          <= '0;
            error          <= 1'b1;
            done[grant_id] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          error <= 1'b0;
          if (grant_id == IDW'(NUM_REQ - 1)) ptr <= '0;
          else                               ptr <= grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exponent_arbiter.sv
// Bench for exponent_arbiter: behavioural exponent stub, directed requests,
// and a scoreboard queue popped by a monitor on every done pulse.
module tb_exponent_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] x_in, a_in;
  logic [3:0]   done;
  logic         error;
  logic [31:0]  p_out;
  logic         busy;
  logic [1:0]   grant_id;
  logic         exp_enable;
  logic [31:0]  exp_x, exp_a;
  logic         exp_ready = 1'b0;
  logic [31:0]  exp_p = '0;

  exponent_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .a_in(a_in),
    .done(done), .error(error), .p_out(p_out), .busy(busy), .grant_id(grant_id),
    .exp_enable(exp_enable), .exp_x(exp_x), .exp_a(exp_a),
    .exp_ready(exp_ready), .exp_p(exp_p)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Behavioural exponent unit. Mode 0: ready after stub_lat cycles.
  // Mode 1: never ready. Mode 2: stale ready/value held through ISSUE and SKIP.
  int          stub_mode = 0;
  int          stub_lat  = 2;
  logic        stub_act  = 1'b0;
  logic        stub_served = 1'b0;
  int          stub_ph   = 0;
  logic [31:0] stub_res  = '0;

  function automatic logic [31:0] pw(input logic [31:0] x, input logic [31:0] a);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < int'(a); i++) r = r * x;
    return r;
  endfunction

  always @(posedge clock) begin
    if (exp_enable) begin
      stub_act <= 1'b1;
      stub_ph  <= 1;
      stub_res <= pw(exp_x, exp_a);
      if (stub_mode != 2) exp_ready <= 1'b0;
    end else if (stub_act) begin
      stub_ph <= stub_ph + 1;
      if (stub_mode == 2 && stub_ph == 1) exp_ready <= 1'b0;
      if (stub_mode != 1 && stub_ph == stub_lat) begin
        exp_ready <= 1'b1;
        exp_p     <= stub_res;
        stub_act  <= 1'b0;
        if (stub_mode == 2) stub_served <= 1'b1;
      end
    end else if (stub_mode == 2 && !stub_served) begin
      exp_ready <= 1'b1;
      exp_p     <= 32'hDEAD_BEEF;
    end
  end

  typedef struct {
    logic [3:0]  d;
    logic [31:0] p;
    logic        e;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0, issue_cyc = 0, done_cyc = 0, en_cnt = 0;

  always @(negedge clock) begin
    exp_t e;
    cyc <= cyc + 1;
    if (exp_enable) begin
      issue_cyc <= cyc;
      en_cnt    <= en_cnt + 1;
    end
    if (done != 4'b0) begin
      done_cyc <= cyc;
      if (sbq.size() == 0) begin
        check("unexpected_done", {60'b0, done}, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("done_vec", {60'b0, done}, {60'b0, e.d});
        check("p_out", {32'b0, p_out}, {32'b0, e.p});
        check("error", {63'b0, error}, {63'b0, e.e});
      end
    end
  end

  task automatic set_ops(input int i, input logic [31:0] x, input logic [31:0] a);
    x_in[32*i +: 32] = x;
    a_in[32*i +: 32] = a;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {55'b0, done, error, busy, grant_id, exp_enable}, 64'd0);
    check({tag, "_p_out"}, {32'b0, p_out}, 64'd0);
    check({tag, "_exp_x"}, {32'b0, exp_x}, 64'd0);
    check({tag, "_exp_a"}, {32'b0, exp_a}, 64'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Requester model: drop req on its done, optionally re-raise 2 cycles later.
  task automatic service(input int ndone, input bit reraise);
    int rr[4];
    int got, n;
    for (int i = 0; i < 4; i++) rr[i] = 0;
    got = 0;
    n   = 0;
    while (got < ndone && n < 300) begin
      tick();
      n++;
      for (int i = 0; i < 4; i++)
        if (rr[i] > 0) begin
          rr[i]--;
          if (rr[i] == 0) req[i] = 1'b1;
        end
      for (int i = 0; i < 4; i++)
        if (done[i]) begin
          req[i] = 1'b0;
          got++;
          if (reraise) rr[i] = 2;
        end
    end
    check("service_count", 64'(got), 64'(ndone));
    req = '0;
  endtask

  task automatic wait_enable();
    int n;
    n = 0;
    while (!exp_enable && n < 50) begin
      tick();
      n++;
    end
    check("enable_seen", {63'b0, exp_enable}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, k;
    reset = 1'b1;
    req   = '0;
    x_in  = '0;
    a_in  = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_zero("reset");

    // Round-robin with all requesters pending
    for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 2), 32'd3);
    sbq.push_back('{4'b0001, 32'd8,   1'b0});
    sbq.push_back('{4'b0010, 32'd27,  1'b0});
    sbq.push_back('{4'b0100, 32'd64,  1'b0});
    sbq.push_back('{4'b1000, 32'd125, 1'b0});
    sbq.push_back('{4'b0001, 32'd8,   1'b0});
    req = 4'b1111;
    service(5, 1'b1);
    repeat (2) tick();

    // Single request: 2^30
    set_ops(0, 32'd2, 32'd30);
    sbq.push_back('{4'b0001, 32'h4000_0000, 1'b0});
    en0 = en_cnt;
    req = 4'b0001;
    tick();
    check("single_enable", {63'b0, exp_enable}, 64'd1);
    check("single_grant", {62'b0, grant_id}, 64'd0);
    check("single_exp_x", {32'b0, exp_x}, 64'd2);
    check("single_exp_a", {32'b0, exp_a}, 64'd30);
    tick();
    check("single_enable_off", {63'b0, exp_enable}, 64'd0);
    k = 0;
    while (done == 4'b0 && k < 50) begin
      tick();
      k++;
    end
    req = '0;
    check("single_done", {60'b0, done}, 64'd1);
    tick();
    check("single_busy_off", {63'b0, busy}, 64'd0);
    check("single_enable_count", 64'(en_cnt - en0), 64'd1);
    repeat (2) tick();

    // Serve requester 3, then pointer wraps so 0 beats 3
    set_ops(3, 32'd5, 32'd3);
    sbq.push_back('{4'b1000, 32'd125, 1'b0});
    req = 4'b1000;
    service(1, 1'b0);
    repeat (2) tick();
    set_ops(0, 32'd2, 32'd3);
    sbq.push_back('{4'b0001, 32'd8,   1'b0});
    sbq.push_back('{4'b1000, 32'd125, 1'b0});
    req = 4'b1001;
    service(2, 1'b0);
    repeat (2) tick();

    // Requester 1 drops req during WAIT; result still delivered
    stub_lat = 4;
    set_ops(1, 32'd3, 32'd4);
    sbq.push_back('{4'b0010, 32'd81, 1'b0});
    req = 4'b0010;
    wait_enable();
    repeat (2) tick();
    req = '0;
    check("midop_busy", {63'b0, busy}, 64'd1);
    service(1, 1'b0);
    stub_lat = 2;
    repeat (2) tick();

    // Timeout: unit never answers
    stub_mode = 1;
    set_ops(2, 32'd9, 32'd9);
    sbq.push_back('{4'b0100, 32'd0, 1'b1});
    req = 4'b0100;
    service(1, 1'b0);
    tick();
    check("timeout_latency", 64'(done_cyc - issue_cyc), 64'd18);
    stub_mode = 0;
    repeat (2) tick();
    sbq.push_back('{4'b1000, 32'd125, 1'b0});
    req = 4'b1000;
    service(1, 1'b0);
    repeat (2) tick();

    // Stale ready held through ISSUE and SKIP
    stub_mode = 2;
    stub_lat  = 6;
    repeat (3) tick();
    set_ops(0, 32'd7, 32'd2);
    sbq.push_back('{4'b0001, 32'd49, 1'b0});
    req = 4'b0001;
    service(1, 1'b0);
    tick();
    check("stale_latency", 64'(done_cyc - issue_cyc), 64'd8);
    stub_mode = 0;
    stub_lat  = 2;
    repeat (2) tick();

    // Reset during WAIT: no done, outputs cleared, pointer back to 0
    stub_mode = 1;
    set_ops(2, 32'd3, 32'd3);
    req = 4'b0100;
    wait_enable();
    repeat (4) tick();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    check_zero("midop_reset");
    stub_mode = 0;
    repeat (2) tick();
    set_ops(0, 32'd4, 32'd2);
    set_ops(3, 32'd5, 32'd3);
    sbq.push_back('{4'b0001, 32'd16,  1'b0});
    sbq.push_back('{4'b1000, 32'd125, 1'b0});
    req = 4'b1001;
    service(2, 1'b0);

    repeat (5) tick();
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exponent_arbiter.md
# exponent_arbiter

Round-robin arbiter and sequencer that shares one `exponent` unit (p = x^a, 32-bit) between NUM_REQ independent requesters. It captures the winning requester's operands and pulses the unit's `enable`. It then waits for `ready`, returns `p` to that requester with a one-cycle `done` pulse, and flags an error if the unit never responds. It sits between the requester-side logic and a single `exponent` instance in the accelerator top level.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- TIMEOUT, default 4096: maximum cycles spent in WAIT before aborting.
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level. Held high until `done[i]`; dropped on the edge where `done[i]` is sampled.
- x_in  in  32*NUM_REQ  base operands; slice i is bits [32i+31:32i]. Stable while `req[i]` is high.
- a_in  in  32*NUM_REQ  exponent operands; same slicing.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
- error  out  1  high together with `done` when the operation timed out.
- p_out  out  32  result; valid only in the cycle `done` is high.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the requester being served; holds its value in IDLE.
- exp_enable  out  1  start pulse to `exponent`.
- exp_x, exp_a  out  32 each  operands to `exponent`, registered, constant from ISSUE through DONE.
- exp_ready  in  1  `exponent` completion flag.
- exp_p  in  32  `exponent` result.

## Operation
- States: IDLE, ISSUE, SKIP, WAIT, DONE.
- **IDLE**
  - If any `req` bit is high, select the first set bit at or after `ptr`, searching upward with wrap-around.
  - Load `grant_id`, `exp_x` and `exp_a` from that requester's operand slices, then go to ISSUE.
- **ISSUE**
  - `exp_enable` = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to SKIP.
- **SKIP**
  - `exp_ready` is ignored in this cycle, because the unit may still show its stale ready.
  - Go to WAIT.
- **WAIT**
  - If `exp_ready` = 1: register `exp_p` into `p_out`, set `error` = 0, go to DONE.
  - Otherwise, if the counter equals TIMEOUT-1: set `p_out` = 0 and `error` = 1, go to DONE.
  - Otherwise increment the counter.
- **DONE**
  - `done[grant_id]` = 1.
  - Set `ptr` = (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
- Arbitration happens only in IDLE. `req` changes in the other states have no effect.
- `ptr` resets to 0. It advances only in DONE, including on timeout.
- If `req[grant_id]` drops mid-operation, the operation still completes and `done` still pulses; the requester discards the result.
- A timeout does not reset the `exponent` unit. Recovering the unit is the top level's job.
- Reset: all outputs are 0. State = IDLE, `ptr` = 0, counter = 0, `grant_id` = 0. Reset in any state aborts the operation with no `done` pulse.

## Timing
- `req[i]` is first high in IDLE cycle c:
  - c+1: ISSUE (`exp_enable` high).
  - c+2: SKIP.
  - c+3 onward: WAIT.
- `exp_ready` sampled high in WAIT cycle w gives `done`/`p_out` in cycle w+1, then IDLE in w+2.
- Arbiter overhead is 4 cycles per operation plus the unit's latency.
- A different pending requester can be granted in the first IDLE cycle after DONE, so back-to-back service has no extra gap.
- A timeout produces DONE exactly TIMEOUT cycles after entering WAIT.
- All outputs are registered. No combinational path from `req` or `exp_ready` to any output.

## Test plan
- **Single request.** NUM_REQ=4 with the real `exponent` unit. `req[0]`, x=2, a=30.
  - Required: one `exp_enable` pulse; `done` = 4'b0001; `p_out` = 32'h4000_0000; `error` = 0; `busy` low again one cycle after `done`.
- **Round-robin.** `req` = 4'b1111 held, operands x_i = i+2, a_i = 3.
  - Required: served in order 0,1,2,3,0; `p_out` = 8, 27, 64, 125 respectively.
  - Between requests, each requester drops `req` on its `done` and re-raises it 2 cycles later.
- **Pointer wrap.** After serving requester 3, raise `req` = 4'b1001.
  - Required: requester 0 is granted before requester 3.
- **Timeout.** Behavioural `exponent` stub that never asserts ready, TIMEOUT=16.
  - Required: `done` and `error` both high exactly 16 cycles after WAIT entry; `p_out` = 0; the next request is accepted normally.
- **Mid-operation changes.** Drop `req[1]` during WAIT with x=3, a=4.
  - Required: `done[1]` still pulses with `p_out` = 81.
  - Separately, assert `reset` during WAIT. Required: no `done`, all outputs 0 on the next cycle, `ptr` = 0.
- **Stale ready.** Stub holds `exp_ready` = 1 in ISSUE and SKIP, drops it, then raises it after 5 cycles.
  - Required: `done` is not issued early; `p_out` equals the stub's value from the later ready.
